// File: rtl/meas_pkg.sv
// Shared definitions for the measurement sequencer: FSM states, mode codes
// and the 32-bit count type used by every cycle counter in the block.
package meas_pkg;

    typedef logic [31:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FREQ_GATE,
        ST_FREQ_LATCH,
        ST_PHASE_ARM,
        ST_PHASE_LATCH,
        ST_HOLD
    } state_t;

    localparam logic [1:0] MODE_FREQ  = 2'd0;
    localparam logic [1:0] MODE_PHASE = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // The reserved code behaves exactly like frequency-only.
    function automatic logic [1:0] normMode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_FREQ : m;
    endfunction

endpackage

// File: rtl/meas_cycle_timer.sv
// Load/expire down-counter shared by the gate, hold and timeout intervals.
// Loading N on a state's entry edge makes o_expire high during the N-th
// cycle of that state. The count saturates at zero and never wraps.
module meas_cycle_timer
    import meas_pkg::*;
(
    input  logic   sys_clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  count_t i_loadVal,
    output logic   o_expire
);

    count_t r_count;

    // Reload on request, otherwise count down and stop at zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - count_t'(1);
        end
    end

    assign o_expire = (r_count <= count_t'(1));

endmodule

// File: rtl/meas_sequencer.sv
// Measurement run sequencer: clears the datapath counters, gates the
// frequency counter, arms the phase detector and latches results.
// Optional feature macro: MEAS_TIMEOUT_EN adds a sticky phase-wait timeout;
// without it the phase wait is unbounded and timeout_err is tied low.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 100_000_000,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont_en,
    input  logic [1:0]  mode,
    input  logic [31:0] freq_cnt,
    input  logic [31:0] phase_cnt,
    input  logic        phase_done,
    output logic        cnt_clr,
    output logic        freq_gate,
    output logic        phase_arm,
    output logic [31:0] result,
    output logic        result_sel,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam count_t GATE_LOAD    = count_t'(GATE_CYCLES);
    localparam count_t HOLD_LOAD    = count_t'(HOLD_CYCLES);
    localparam count_t TIMEOUT_LOAD = count_t'(TIMEOUT_CYCLES);

    state_t     r_state;
    logic [1:0] r_mode;
    logic       r_cntClr;
    logic       r_freqGate;
    logic       r_phaseArm;
    count_t     r_result;
    logic       r_resultSel;
    logic       r_resultValid;
    logic       r_busy;
`ifdef MEAS_TIMEOUT_EN
    logic       r_timeoutErr;
`endif

    logic       w_tmrLoad;
    count_t     w_tmrVal;
    logic       w_expire;

    meas_cycle_timer u_timer (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .i_load    (w_tmrLoad),
        .i_loadVal (w_tmrVal),
        .o_expire  (w_expire)
    );

    // Load the timer on the edge that enters each timed state.
    always_comb begin
        w_tmrLoad = 1'b0;
        w_tmrVal  = '0;
        case (r_state)
            ST_CLEAR: begin
                w_tmrLoad = 1'b1;
                w_tmrVal  = (r_mode == MODE_PHASE) ? TIMEOUT_LOAD : GATE_LOAD;
            end
            ST_FREQ_LATCH: begin
                w_tmrLoad = 1'b1;
                w_tmrVal  = (r_mode == MODE_ALT) ? TIMEOUT_LOAD : HOLD_LOAD;
            end
            ST_PHASE_LATCH: begin
                w_tmrLoad = 1'b1;
                w_tmrVal  = HOLD_LOAD;
            end
`ifdef MEAS_TIMEOUT_EN
            ST_PHASE_ARM: begin
                w_tmrLoad = w_expire && !phase_done;
                w_tmrVal  = HOLD_LOAD;
            end
`endif
            default: begin
                w_tmrLoad = 1'b0;
                w_tmrVal  = '0;
            end
        endcase
    end

    // Sequencer FSM; every output is registered alongside the state so it
    // is valid for exactly the cycles spent in the matching state.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_FREQ;
            r_cntClr      <= 1'b0;
            r_freqGate    <= 1'b0;
            r_phaseArm    <= 1'b0;
            r_result      <= '0;
            r_resultSel   <= 1'b0;
            r_resultValid <= 1'b0;
            r_busy        <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
            r_timeoutErr  <= 1'b0;
`endif
        end else begin
            r_resultValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_CLEAR;
                        r_mode   <= normMode(mode);
                        r_cntClr <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef MEAS_TIMEOUT_EN
                        r_timeoutErr <= 1'b0;
`endif
                    end
                end
                ST_CLEAR: begin
                    r_cntClr <= 1'b0;
                    if (r_mode == MODE_PHASE) begin
                        r_state    <= ST_PHASE_ARM;
                        r_phaseArm <= 1'b1;
                    end else begin
                        r_state    <= ST_FREQ_GATE;
                        r_freqGate <= 1'b1;
                    end
                end
                ST_FREQ_GATE: begin
                    if (w_expire) begin
                        r_state    <= ST_FREQ_LATCH;
                        r_freqGate <= 1'b0;
                    end
                end
                ST_FREQ_LATCH: begin
                    r_result      <= freq_cnt;
                    r_resultSel   <= 1'b0;
                    r_resultValid <= 1'b1;
                    if (r_mode == MODE_ALT) begin
                        r_state    <= ST_PHASE_ARM;
                        r_phaseArm <= 1'b1;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_PHASE_ARM: begin
                    if (phase_done) begin
                        r_state    <= ST_PHASE_LATCH;
                        r_phaseArm <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
                    end else if (w_expire) begin
                        r_state      <= ST_HOLD;
                        r_phaseArm   <= 1'b0;
                        r_timeoutErr <= 1'b1;
`endif
                    end
                end
                ST_PHASE_LATCH: begin
                    r_result      <= phase_cnt;
                    r_resultSel   <= 1'b1;
                    r_resultValid <= 1'b1;
                    r_state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_expire) begin
                        if (cont_en) begin
                            r_state  <= ST_CLEAR;
                            r_cntClr <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cntClr   <= 1'b0;
                    r_freqGate <= 1'b0;
                    r_phaseArm <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_clr      = r_cntClr;
    assign freq_gate    = r_freqGate;
    assign phase_arm    = r_phaseArm;
    assign result       = r_result;
    assign result_sel   = r_resultSel;
    assign result_valid = r_resultValid;
    assign busy         = r_busy;
`ifdef MEAS_TIMEOUT_EN
    assign timeout_err  = r_timeoutErr;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_meas_sequencer.sv
// Testbench for meas_sequencer. Expected behaviour is built as a per-cycle
// timeline from the run rules (segment lengths per state), with randomized
// noise on inputs the design must ignore.
module tb_meas_sequencer;

    localparam int GATE  = 10;
    localparam int HOLDC = 5;
    localparam int TOUT  = 20;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] freq_cnt = '0;
    logic [31:0] phase_cnt = '0;
    logic        phase_done = 1'b0;
    logic        cnt_clr, freq_gate, phase_arm, result_sel, result_valid, busy, timeout_err;
    logic [31:0] result;

    meas_sequencer #(
        .GATE_CYCLES    (GATE),
        .HOLD_CYCLES    (HOLDC),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont_en      (cont_en),
        .mode         (mode),
        .freq_cnt     (freq_cnt),
        .phase_cnt    (phase_cnt),
        .phase_done   (phase_done),
        .cnt_clr      (cnt_clr),
        .freq_gate    (freq_gate),
        .phase_arm    (phase_arm),
        .result       (result),
        .result_sel   (result_sel),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        start;
        logic        contEn;
        logic        phaseDone;
        logic [1:0]  mode;
        logic [31:0] freqCnt;
        logic [31:0] phaseCnt;
        logic        expClr;
        logic        expGate;
        logic        expArm;
        logic        expBusy;
        logic        expValid;
        logic        expSel;
        logic        expTerr;
        logic [31:0] expResult;
    } cycleRec_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] fc;
        logic [31:0] pc;
        int          d;
        int          runs;
        int          wantStrobes;
        logic [31:0] wantResult;
        logic        wantSel;
    } scen_t;

    cycleRec_t   trace[$];
    int          numChecks = 0;
    int          numBad = 0;
    logic [31:0] curResult = '0;
    logic        curSel = 1'b0;
    logic        curTerr = 1'b0;
    logic        pendValid = 1'b0;
    int          expStrobes = 0;
    int          seenStrobes = 0;

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        numChecks++;
        if (got !== want) begin
            numBad++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input int k, input cycleRec_t r);
        numChecks++;
        if ({cnt_clr, freq_gate, phase_arm, busy, result_valid, result_sel, timeout_err} !==
            {r.expClr, r.expGate, r.expArm, r.expBusy, r.expValid, r.expSel, r.expTerr} ||
            result !== r.expResult) begin
            numBad++;
            $display("[TB] FAIL %s cycle %0d: got clr=%b gate=%b arm=%b busy=%b valid=%b sel=%b terr=%b result=%h; want clr=%b gate=%b arm=%b busy=%b valid=%b sel=%b terr=%b result=%h",
                     name, k, cnt_clr, freq_gate, phase_arm, busy, result_valid, result_sel, timeout_err, result,
                     r.expClr, r.expGate, r.expArm, r.expBusy, r.expValid, r.expSel, r.expTerr, r.expResult);
        end
    endtask

    // One cycle of expectation with random values on inputs that must not matter.
    task automatic makeRec(input logic clr, input logic gate, input logic arm, input logic bsy,
                           output cycleRec_t r);
        r.start     = bsy ? 1'($urandom_range(0, 1)) : 1'b0;
        r.contEn    = 1'($urandom_range(0, 1));
        r.mode      = 2'($urandom_range(0, 3));
        r.phaseDone = arm ? 1'b0 : 1'($urandom_range(0, 1));
        r.freqCnt   = $urandom;
        r.phaseCnt  = $urandom;
        r.expClr    = clr;
        r.expGate   = gate;
        r.expArm    = arm;
        r.expBusy   = bsy;
        r.expValid  = pendValid;
        if (pendValid) expStrobes++;
        pendValid   = 1'b0;
        r.expResult = curResult;
        r.expSel    = curSel;
        r.expTerr   = curTerr;
    endtask

    task automatic pushIdle(input int n);
        cycleRec_t r;
        for (int i = 0; i < n; i++) begin
            makeRec(1'b0, 1'b0, 1'b0, 1'b0, r);
            trace.push_back(r);
        end
    endtask

    // Timeline of a start pulse followed by `runs` back-to-back runs.
    task automatic buildRun(input logic [1:0] m, input logic [31:0] fc, input logic [31:0] pc,
                            input int d, input int runs);
        cycleRec_t  r;
        logic [1:0] eff;
        int         armLen;
        logic       timedOut;
        eff = (m == 2'd3) ? 2'd0 : m;
        makeRec(1'b0, 1'b0, 1'b0, 1'b0, r);
        r.start = 1'b1;
        r.mode  = m;
        trace.push_back(r);
        curTerr = 1'b0;
        for (int run = 0; run < runs; run++) begin
            makeRec(1'b1, 1'b0, 1'b0, 1'b1, r);
            trace.push_back(r);
            if (eff != 2'd1) begin
                for (int i = 0; i < GATE; i++) begin
                    makeRec(1'b0, 1'b1, 1'b0, 1'b1, r);
                    trace.push_back(r);
                end
                makeRec(1'b0, 1'b0, 1'b0, 1'b1, r);
                r.freqCnt = fc;
                trace.push_back(r);
                curResult = fc;
                curSel    = 1'b0;
                pendValid = 1'b1;
            end
            if (eff != 2'd0) begin
                armLen   = d;
                timedOut = 1'b0;
`ifdef MEAS_TIMEOUT_EN
                if (d > TOUT) begin
                    armLen   = TOUT;
                    timedOut = 1'b1;
                end
`endif
                for (int i = 1; i <= armLen; i++) begin
                    makeRec(1'b0, 1'b0, 1'b1, 1'b1, r);
                    r.phaseDone = !timedOut && (i == d);
                    trace.push_back(r);
                end
                if (timedOut) begin
                    curTerr = 1'b1;
                end else begin
                    makeRec(1'b0, 1'b0, 1'b0, 1'b1, r);
                    r.phaseCnt = pc;
                    trace.push_back(r);
                    curResult = pc;
                    curSel    = 1'b1;
                    pendValid = 1'b1;
                end
            end
            for (int i = 1; i <= HOLDC; i++) begin
                makeRec(1'b0, 1'b0, 1'b0, 1'b1, r);
                if (i == HOLDC) r.contEn = (run < runs - 1);
                else if (run == runs - 1) r.contEn = 1'b1;
                trace.push_back(r);
            end
        end
    endtask

    // Check each cycle's outputs mid-cycle, then drive that cycle's inputs.
    task automatic applyStimulus(input string name);
        seenStrobes = 0;
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge sys_clk);
            checkOutput(name, k, trace[k]);
            if (result_valid) seenStrobes++;
            start      = trace[k].start;
            cont_en    = trace[k].contEn;
            mode       = trace[k].mode;
            phase_done = trace[k].phaseDone;
            freq_cnt   = trace[k].freqCnt;
            phase_cnt  = trace[k].phaseCnt;
        end
    endtask

    task automatic checkAllReset(input string name);
        checkValue({name, " cnt_clr"},      32'(cnt_clr), 32'd0);
        checkValue({name, " freq_gate"},    32'(freq_gate), 32'd0);
        checkValue({name, " phase_arm"},    32'(phase_arm), 32'd0);
        checkValue({name, " result"},       result, 32'd0);
        checkValue({name, " result_sel"},   32'(result_sel), 32'd0);
        checkValue({name, " result_valid"}, 32'(result_valid), 32'd0);
        checkValue({name, " busy"},         32'(busy), 32'd0);
        checkValue({name, " timeout_err"},  32'(timeout_err), 32'd0);
    endtask

    scen_t     tbl[7];
    cycleRec_t rr;

    initial begin
        tbl[0] = '{2'd0, 32'd1234,      32'h0,        0,    1, 1, 32'd1234,      1'b0};
        tbl[1] = '{2'd2, 32'h00ABCDEF,  32'h55,       7,    1, 2, 32'h55,        1'b1};
        tbl[2] = '{2'd1, 32'h0,         32'hDEAD0001, 3,    1, 1, 32'hDEAD0001,  1'b1};
        tbl[3] = '{2'd3, 32'h77,        32'h0,        0,    1, 1, 32'h77,        1'b0};
        tbl[4] = '{2'd0, 32'h1000,      32'h0,        0,    3, 3, 32'h1000,      1'b0};
        tbl[5] = '{2'd2, 32'hF00D,      32'hBEEF,     1,    2, 4, 32'hBEEF,      1'b1};
        tbl[6] = '{2'd1, 32'h0,         32'h2020,     TOUT, 1, 1, 32'h2020,      1'b1};

        repeat (3) @(negedge sys_clk);
        checkAllReset("reset");
        rst_n = 1'b1;

        foreach (tbl[s]) begin
            trace.delete();
            expStrobes = 0;
            pushIdle(2);
            buildRun(tbl[s].mode, tbl[s].fc, tbl[s].pc, tbl[s].d, tbl[s].runs);
            pushIdle(3);
            applyStimulus($sformatf("table%0d", s));
            checkValue($sformatf("table%0d strobes", s), 32'(seenStrobes), 32'(tbl[s].wantStrobes));
            checkValue($sformatf("table%0d result", s), result, tbl[s].wantResult);
            checkValue($sformatf("table%0d sel", s), 32'(result_sel), 32'(tbl[s].wantSel));
        end

        for (int n = 0; n < 8; n++) begin
            trace.delete();
            expStrobes = 0;
            pushIdle(int'($urandom_range(1, 3)));
            buildRun(2'($urandom_range(0, 3)), $urandom, $urandom,
                     int'($urandom_range(1, TOUT)), int'($urandom_range(1, 2)));
            pushIdle(2);
            applyStimulus($sformatf("random%0d", n));
            checkValue($sformatf("random%0d strobes", n), 32'(seenStrobes), 32'(expStrobes));
        end

        // Reset in the middle of the frequency gate.
        trace.delete();
        pushIdle(1);
        makeRec(1'b0, 1'b0, 1'b0, 1'b0, rr);
        rr.start = 1'b1;
        rr.mode  = 2'd0;
        trace.push_back(rr);
        curTerr = 1'b0;
        makeRec(1'b1, 1'b0, 1'b0, 1'b1, rr);
        trace.push_back(rr);
        for (int i = 0; i < 4; i++) begin
            makeRec(1'b0, 1'b1, 1'b0, 1'b1, rr);
            trace.push_back(rr);
        end
        applyStimulus("pre-reset");
        #2;
        rst_n      = 1'b0;
        start      = 1'b0;
        phase_done = 1'b0;
        #1;
        checkAllReset("midgate reset");
        repeat (2) @(negedge sys_clk);
        rst_n     = 1'b1;
        curResult = '0;
        curSel    = 1'b0;
        curTerr   = 1'b0;
        pendValid = 1'b0;
        trace.delete();
        expStrobes = 0;
        pushIdle(4);
        buildRun(2'd0, 32'h3456, 32'h0, 0, 1);
        pushIdle(2);
        applyStimulus("post-reset");
        checkValue("post-reset strobes", 32'(seenStrobes), 32'd1);

        // Phase wait without phase_done.
        trace.delete();
        expStrobes = 0;
        pushIdle(2);
        buildRun(2'd1, 32'h0, 32'h9999, TOUT + 8, 1);
        pushIdle(2);
        applyStimulus("phase-wait");
`ifdef MEAS_TIMEOUT_EN
        checkValue("timeout flag", 32'(timeout_err), 32'd1);
        checkValue("timeout strobes", 32'(seenStrobes), 32'd0);
        checkValue("timeout result kept", result, 32'h3456);
        trace.delete();
        pushIdle(1);
        buildRun(2'd0, 32'h42, 32'h0, 0, 1);
        pushIdle(2);
        applyStimulus("after-timeout");
        checkValue("timeout cleared", 32'(timeout_err), 32'd0);
`else
        checkValue("long wait strobes", 32'(seenStrobes), 32'd1);
        checkValue("long wait result", result, 32'h9999);
        checkValue("timeout tied low", 32'(timeout_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", numChecks, numBad);
        $finish;
    end

endmodule

// File: doc/meas_sequencer.md
MEAS_SEQUENCER -- requirements
Module: meas_sequencer

Interface
REQ-001 The module SHALL have parameter GATE_CYCLES, default 100_000_000, giving the frequency gate length in sys_clk cycles (1 s at 100 MHz).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 50_000_000, giving the result hold time before the next measurement in continuous mode.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 200_000_000, giving the phase-wait limit.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a measurement run.
REQ-007 cont_en  in  1  continuous mode: repeat runs until cleared.
REQ-008 mode  in  2  0 = frequency only, 1 = phase only, 2 = alternate frequency then phase, 3 = reserved (treated as 0).
REQ-009 freq_cnt  in  32  edge count from the frequency datapath.
REQ-010 phase_cnt  in  32  phase-difference count from the phase datapath.
REQ-011 phase_done  in  1  datapath pulse: phase count is complete and stable.
REQ-012 cnt_clr  out  1  clears both datapath counters.
REQ-013 freq_gate  out  1  enables frequency counting.
REQ-014 phase_arm  out  1  enables the phase detector.
REQ-015 result  out  32  latched measurement value.
REQ-016 result_sel  out  1  0 = result is frequency, 1 = result is phase.
REQ-017 result_valid  out  1  one-cycle strobe when result updates.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 timeout_err  out  1  sticky phase-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, FREQ_GATE, FREQ_LATCH, PHASE_ARM, PHASE_LATCH, HOLD.
REQ-021 IDLE -> CLEAR on start=1; start SHALL be ignored in all other states.
REQ-022 CLEAR SHALL last exactly 1 cycle with cnt_clr=1, then go to FREQ_GATE (mode 0/2/3) or PHASE_ARM (mode 1).
REQ-023 mode SHALL be sampled only in IDLE when start is accepted; changes mid-run take effect on the next run.
REQ-024 freq_gate SHALL be high for exactly GATE_CYCLES consecutive cycles in FREQ_GATE.
REQ-025 FREQ_LATCH SHALL last 1 cycle: result<=freq_cnt, result_sel<=0, result_valid=1 on the following cycle; then PHASE_ARM if mode=2, else HOLD.
REQ-026 In PHASE_ARM, phase_arm=1 until phase_done; phase_done -> PHASE_LATCH.
REQ-027 PHASE_LATCH SHALL capture result<=phase_cnt, result_sel<=1, pulse result_valid, then go to HOLD.
REQ-028 A mode-2 run SHALL therefore produce exactly two result_valid pulses, frequency first.
REQ-029 HOLD SHALL wait HOLD_CYCLES, then go to CLEAR if cont_en=1, else IDLE; cont_en is sampled on the last HOLD cycle.
REQ-030 phase_done outside PHASE_ARM SHALL be ignored.
REQ-031 Cycle counters SHALL be 32-bit, reload to 0 on state entry, and never wrap within a state.
REQ-032 result SHALL hold its value between strobes and SHALL NOT change on timeout.

Reset
REQ-033 On rst_n=0, immediately: state=IDLE, cnt_clr=0, freq_gate=0, phase_arm=0, result=0, result_sel=0, result_valid=0, busy=0, timeout_err=0.
REQ-034 Reset mid-run SHALL abort with no result_valid pulse; after release the block waits for start.

Configuration
REQ-035 With MEAS_TIMEOUT_EN defined, PHASE_ARM exceeding TIMEOUT_CYCLES SHALL set timeout_err=1 and go to HOLD without a result_valid pulse. timeout_err SHALL clear on the next accepted start.
REQ-036 Without MEAS_TIMEOUT_EN, PHASE_ARM SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-037 A shared package meas_pkg SHALL hold the state enum, the mode encodings and the 32-bit count type.
REQ-038 A single sub-module, meas_cycle_timer (load/expire down-counter), SHALL be reused for the gate, hold and timeout timing.

Verification
REQ-039 Verify mode 0 with GATE_CYCLES=10, freq_cnt=1234, start pulse: cnt_clr for 1 cycle, freq_gate high for 10 cycles, result=1234, result_sel=0, one strobe, then IDLE.
REQ-040 Verify mode 2 with phase_done 7 cycles after arm and phase_cnt=0x55: two strobes in order, result=freq then 0x55, result_sel 0 then 1.
REQ-041 Verify cont_en=1 with HOLD_CYCLES=5: the next CLEAR follows 5 cycles after the strobe; deasserting cont_en in HOLD returns to IDLE.
REQ-042 Verify with MEAS_TIMEOUT_EN defined, TIMEOUT_CYCLES=20 and no phase_done: timeout_err=1 after 20 cycles, no strobe, result unchanged; a new start clears the flag.
REQ-043 Verify rst_n asserted mid-FREQ_GATE: all outputs reset immediately, no strobe, and start is accepted again after release.
REQ-044 Verify start re-pulsed while busy and phase_done pulsed in IDLE: both are ignored and the sequence is unchanged.
